// File: rtl/image_control_if.sv
// Pixel stream in / 3x3 window stream out bundle for image_control.
interface image_control_if;
  logic [7:0]  i_pixel_data;
  logic        i_pixel_data_valid;
  logic        o_in_ready;
  logic [71:0] o_pixel_data;
  logic        o_pixel_data_valid;
  logic        o_intr;

  modport master (
    output i_pixel_data,
    output i_pixel_data_valid,
    input  o_in_ready,
    input  o_pixel_data,
    input  o_pixel_data_valid,
    input  o_intr
  );

  modport slave (
    input  i_pixel_data,
    input  i_pixel_data_valid,
    output o_in_ready,
    output o_pixel_data,
    output o_pixel_data_valid,
    output o_intr
  );
endinterface

// File: rtl/image_control.sv
// Four rotating line buffers feeding a 3x3 sliding window; the three oldest
// complete lines are read out together while the fourth is being written.
package definitions_pkg;
  parameter int unsigned IMAGE_WIDTH = 512;
endpackage

module line_buffer #(
  parameter int unsigned IMAGE_WIDTH = definitions_pkg::IMAGE_WIDTH
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [7:0]  i_data,
  input  logic        i_data_valid,
  output logic [23:0] o_data,
  input  logic        rd_enable
);
  localparam int unsigned PW = $clog2(IMAGE_WIDTH);

  logic [7:0]    mem [IMAGE_WIDTH];
  logic [PW-1:0] wrPntr;
  logic [PW-1:0] rdPntr;
  logic [PW:0]   rd1;
  logic [PW:0]   rd2;

  always_ff @(posedge clk) begin
    if (i_data_valid) mem[wrPntr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wrPntr <= '0;
      rdPntr <= '0;
    end else begin
      if (i_data_valid)
        wrPntr <= (wrPntr == PW'(IMAGE_WIDTH - 1)) ? '0 : wrPntr + PW'(1);
      if (rd_enable)
        rdPntr <= (rdPntr == PW'(IMAGE_WIDTH - 1)) ? '0 : rdPntr + PW'(1);
    end
  end

  // Columns past the right edge of the line read as zero.
  always_comb begin
    rd1 = {1'b0, rdPntr} + (PW+1)'(1);
    rd2 = {1'b0, rdPntr} + (PW+1)'(2);
    o_data[23:16] = mem[rdPntr];
    o_data[15:8]  = (rd1 < (PW+1)'(IMAGE_WIDTH)) ? mem[rd1[PW-1:0]] : '0;
    o_data[7:0]   = (rd2 < (PW+1)'(IMAGE_WIDTH)) ? mem[rd2[PW-1:0]] : '0;
  end
endmodule

module image_control #(
  parameter int unsigned IMAGE_WIDTH = definitions_pkg::IMAGE_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  image_control_if.slave bus
);
  localparam int unsigned CW = $clog2(4 * IMAGE_WIDTH) + 1;
  localparam int unsigned PW = $clog2(IMAGE_WIDTH);

  typedef enum logic {RD_IDLE = 1'b0, RD_ACTIVE = 1'b1} rd_state_t;

  rd_state_t     state;
  rd_state_t     state_next;
  logic [CW-1:0] pixelCount;
  logic [PW-1:0] wrCount;
  logic [PW-1:0] rdCount;
  logic [1:0]    wrSel;
  logic [1:0]    rdSel;
  logic          in_ready;
  logic          accept;
  logic          rdActive;
  logic          rdLast;
  logic          intr_q;
  logic [3:0]    lb_wr_valid;
  logic [3:0]    lb_rd_enable;
  logic [23:0]   lb_data [4];

  assign in_ready               = pixelCount < CW'(4 * IMAGE_WIDTH);
  assign accept                 = bus.i_pixel_data_valid & in_ready;
  assign rdActive               = (state == RD_ACTIVE);
  assign rdLast                 = rdActive && (rdCount == PW'(IMAGE_WIDTH - 1));
  assign bus.o_in_ready         = in_ready;
  assign bus.o_pixel_data_valid = rdActive;
  assign bus.o_intr             = intr_q;
  assign bus.o_pixel_data       = {lb_data[rdSel], lb_data[rdSel + 2'd1], lb_data[rdSel + 2'd2]};

  for (genvar i = 0; i < 4; i++) begin : g_lb
    line_buffer #(.IMAGE_WIDTH(IMAGE_WIDTH)) u_lb (
      .clk         (clk),
      .rstN        (~rst),
      .i_data      (bus.i_pixel_data),
      .i_data_valid(lb_wr_valid[i]),
      .o_data      (lb_data[i]),
      .rd_enable   (lb_rd_enable[i])
    );
  end

  always_comb begin
    lb_wr_valid        = '0;
    lb_wr_valid[wrSel] = accept;
  end

  // The buffer at rdSel+3 is the one being filled and is never read.
  always_comb begin
    lb_rd_enable                = '0;
    lb_rd_enable[rdSel]         = rdActive;
    lb_rd_enable[rdSel + 2'd1]  = rdActive;
    lb_rd_enable[rdSel + 2'd2]  = rdActive;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrCount <= '0;
      wrSel   <= '0;
    end else if (accept) begin
      if (wrCount == PW'(IMAGE_WIDTH - 1)) begin
        wrCount <= '0;
        wrSel   <= wrSel + 2'd1;
      end else begin
        wrCount <= wrCount + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdCount <= '0;
      rdSel   <= '0;
    end else if (rdActive) begin
      if (rdLast) begin
        rdCount <= '0;
        rdSel   <= rdSel + 2'd1;
      end else begin
        rdCount <= rdCount + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pixelCount <= '0;
    else if (accept && !rdActive)
      pixelCount <= pixelCount + CW'(1);
    else if (!accept && rdActive)
      pixelCount <= pixelCount - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RD_IDLE;
      intr_q <= 1'b0;
    end else begin
      state  <= state_next;
      intr_q <= rdLast;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RD_IDLE:   if (pixelCount >= CW'(3 * IMAGE_WIDTH)) state_next = RD_ACTIVE;
      RD_ACTIVE: if (rdLast) state_next = RD_IDLE;
      default:   state_next = RD_IDLE;
    endcase
  end
endmodule

// File: tb/tb_image_control.sv
// Directed bench for image_control: full-size instance for streaming/windows,
// narrow instance to reach the buffer-full condition quickly.
module tb_image_control;
  localparam int unsigned W    = 512;
  localparam int unsigned SW   = 4;
  localparam int unsigned MEMD = 8192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  image_control_if bus();
  image_control_if sbus();

  image_control #(.IMAGE_WIDTH(W))  dut  (.clk(clk), .rst(rst), .bus(bus));
  image_control #(.IMAGE_WIDTH(SW)) sdut (.clk(clk), .rst(rst), .bus(sbus));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        sel;
  logic        mode;
  int unsigned w;
  logic [7:0]  mem [MEMD];
  int unsigned acc, lvl, rd_line, rd_col;
  logic        m_active, m_intr;
  int          cyc, wr3_cyc, first_vld_cyc;
  int unsigned run, last_run;
  logic        full_seen;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int unsigned g);
    return mode ? 8'(g + 3 * (g / w)) : 8'(g);
  endfunction

  function automatic logic [71:0] golden(input int unsigned line, input int unsigned col);
    logic [71:0] g;
    g = '0;
    for (int unsigned r = 0; r < 3; r++)
      for (int unsigned k = 0; k < 3; k++)
        if (col + k < w) g[71 - 24*r - 8*k -: 8] = mem[((line + r) * w + col + k) % MEMD];
    return g;
  endfunction

  task automatic model_clear();
    acc = 0; lvl = 0; rd_line = 0; rd_col = 0;
    m_active = 1'b0; m_intr = 1'b0;
    cyc = 0; wr3_cyc = -100; first_vld_cyc = -1;
    run = 0; last_run = 0; full_seen = 1'b0;
  endtask

  task automatic do_reset();
    bus.i_pixel_data_valid  = 1'b0;
    bus.i_pixel_data        = '0;
    sbus.i_pixel_data_valid = 1'b0;
    sbus.i_pixel_data       = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_valid",       bus.o_pixel_data_valid, 72'd0);
    check("rst_ready",       bus.o_in_ready,         72'd1);
    check("rst_intr",        bus.o_intr,             72'd0);
    check("rst_pixel_count", 72'(dut.pixelCount),    72'd0);
    check("rst_wr_count",    72'(dut.wrCount),       72'd0);
    check("rst_rd_count",    72'(dut.rdCount),       72'd0);
    check("rst_wr_sel",      72'(dut.wrSel),         72'd0);
    check("rst_rd_sel",      72'(dut.rdSel),         72'd0);
    check("rst_s_valid",     sbus.o_pixel_data_valid, 72'd0);
    check("rst_s_ready",     sbus.o_in_ready,         72'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
  endtask

  // One clock: compare outputs against the model, offer one pixel, advance the model.
  task automatic tick(input logic v);
    logic        rdy, vld, intr, ok;
    logic [71:0] win;
    logic [7:0]  d;
    int unsigned pc, rs;
    if (sel) begin
      rdy = sbus.o_in_ready; vld = sbus.o_pixel_data_valid; intr = sbus.o_intr;
      win = sbus.o_pixel_data; pc = 32'(sdut.pixelCount); rs = 32'(sdut.rdSel);
    end else begin
      rdy = bus.o_in_ready; vld = bus.o_pixel_data_valid; intr = bus.o_intr;
      win = bus.o_pixel_data; pc = 32'(dut.pixelCount); rs = 32'(dut.rdSel);
    end
    check("in_ready",    72'(rdy),  72'(lvl < 4 * w));
    check("valid",       72'(vld),  72'(m_active));
    check("intr",        72'(intr), 72'(m_intr));
    check("pixel_count", 72'(pc),   72'(lvl));
    if (m_active) check("window", win, golden(rd_line, rd_col));
    if (m_active && rd_col == 0) check("rd_sel", 72'(rs), 72'(rd_line % 4));
    if (!rdy) full_seen = 1'b1;
    if (vld && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (vld) run++;
    else if (run != 0) begin last_run = run; run = 0; end

    d = pix(acc);
    if (sel) begin sbus.i_pixel_data_valid = v; sbus.i_pixel_data = d; end
    else     begin bus.i_pixel_data_valid  = v; bus.i_pixel_data  = d; end
    @(posedge clk);
    #1;

    ok = v && (lvl < 4 * w);
    if (ok) begin
      mem[acc % MEMD] = d;
      acc++;
      if (acc == 3 * w) wr3_cyc = cyc;
    end
    m_intr = m_active && (rd_col == w - 1);
    if (m_active) begin
      lvl = lvl + (ok ? 1 : 0) - 1;
      if (rd_col == w - 1) begin
        rd_col   = 0;
        rd_line++;
        m_active = 1'b0;
      end else begin
        rd_col++;
      end
    end else begin
      m_active = (lvl >= 3 * w);
      lvl = lvl + (ok ? 1 : 0);
    end
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; mode = 1'b0; w = W;
    model_clear();
    bus.i_pixel_data_valid = 1'b0;  bus.i_pixel_data = '0;
    sbus.i_pixel_data_valid = 1'b0; sbus.i_pixel_data = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Mid-line reset while reading line 0 and writing line 3.
    for (int unsigned i = 0; i < 3000 && !(m_active && rd_line == 0 && rd_col == 200); i++) tick(1'b1);
    check("mid_rd_count", 72'(dut.rdCount), 72'd200);
    check("mid_wr_sel",   72'(dut.wrSel),   72'd3);
    do_reset();

    // First line after reset: latency, first window, padding, line length, interrupt.
    for (int unsigned i = 0; i < 3000 && !(m_active && rd_line == 0 && rd_col == 0); i++) tick(1'b1);
    check("first_window", bus.o_pixel_data, 72'h000102_000102_000102);
    tick(1'b1);
    check("latency", 72'(first_vld_cyc - wr3_cyc), 72'd2);
    for (int unsigned i = 0; i < 1000 && !(m_active && rd_col == 510); i++) tick(1'b1);
    check("pad_510", bus.o_pixel_data, 72'hFEFF00_FEFF00_FEFF00);
    tick(1'b1);
    check("pad_511", bus.o_pixel_data, 72'hFF0000_FF0000_FF0000);
    tick(1'b1);
    check("intr_pulse", bus.o_intr,             72'd1);
    check("gap_valid",  bus.o_pixel_data_valid, 72'd0);
    tick(1'b1);
    check("line_len", 72'(last_run), 72'd512);
    check("intr_once", bus.o_intr,   72'd0);
    for (int unsigned i = 0; i < 600; i++) tick(1'b1);

    // Distinct rows per line, gapped stream, rdSel wraps past 3.
    do_reset();
    mode = 1'b1;
    for (int unsigned i = 0; i < 20000 && rd_line < 6; i++) tick(1'b1 ^ (i % 7 == 6));
    check("lines_read", 72'(dut.rdSel), 72'd2);

    // Narrow instance: buffer fills, writes stall and are dropped.
    sel = 1'b1; w = SW; mode = 1'b0;
    do_reset();
    for (int unsigned i = 0; i < 150; i++) tick(1'b1);
    check("full_seen", 72'(full_seen), 72'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/image_control.md
IMAGE_CONTROL -- requirements
Module: image_control

Interface
REQ-001 The block SHALL take parameter IMAGE_WIDTH, default IMAGE_WIDTH from definitions_pkg (512), meaning pixels per image line.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port i_pixel_data, input, 8, the incoming grayscale pixel.
REQ-005 The block SHALL have port i_pixel_data_valid, input, 1, marking i_pixel_data valid this cycle.
REQ-006 The block SHALL have port o_in_ready, output, 1, high when a write will be accepted this cycle.
REQ-007 The block SHALL have port o_pixel_data, output, 72, the 3x3 window as {row0[23:0], row1[23:0], row2[23:0]}; row0 is the oldest line.
REQ-008 The block SHALL have port o_pixel_data_valid, output, 1, marking o_pixel_data valid this cycle.
REQ-009 The block SHALL have port o_intr, output, 1, a one-cycle pulse when a full output line has been read.

Function
REQ-010 The block SHALL instantiate four line_buffer instances (LB0-LB3), each with rstN driven by ~rst.
REQ-011 Write acceptance: accept = i_pixel_data_valid & o_in_ready; o_in_ready = (pixelCount < 4*IMAGE_WIDTH), combinational.
REQ-012 On accept, only LB[wrSel] SHALL receive i_data_valid=1; the other three receive 0. i_data of all four SHALL be i_pixel_data.
REQ-013 wrCount (0..IMAGE_WIDTH-1) SHALL increment on accept; on accept at IMAGE_WIDTH-1 it wraps to 0 and wrSel advances mod 4 (3->0).
REQ-014 A write presented while o_in_ready=0 SHALL be dropped: no buffer write, no counter change.
REQ-015 pixelCount (width clog2(4*IMAGE_WIDTH)+1): +1 on accept only, -1 on read only, unchanged when both occur in the same cycle.
REQ-016 The read FSM SHALL have two states, RD_IDLE and RD_ACTIVE; rdActive = (state == RD_ACTIVE).
REQ-017 RD_IDLE -> RD_ACTIVE when pixelCount >= 3*IMAGE_WIDTH, evaluated on the registered count.
REQ-018 RD_ACTIVE -> RD_IDLE when rdCount == IMAGE_WIDTH-1 and a read occurs; there is always at least one RD_IDLE cycle between lines.
REQ-019 A read SHALL occur every cycle rdActive=1; rd_enable of LB[rdSel], LB[rdSel+1], LB[rdSel+2] (mod 4) = rdActive; the fourth buffer's rd_enable = 0.
REQ-020 rdCount (0..IMAGE_WIDTH-1) SHALL increment on each read; at IMAGE_WIDTH-1 it wraps to 0 and rdSel advances mod 4.
REQ-021 o_pixel_data SHALL be combinational: {LB[rdSel].o_data, LB[rdSel+1].o_data, LB[rdSel+2].o_data}, indices mod 4; zero padding at line end is supplied by the line buffers.
REQ-022 o_pixel_data_valid SHALL equal rdActive; latency from the write that makes pixelCount reach 3*IMAGE_WIDTH to the first valid output is 2 cycles.
REQ-023 o_intr SHALL be registered, 1 for exactly the cycle after the last read of a line, and 0 otherwise.
REQ-024 Pointer wrap: wrSel and rdSel wrap 3->0 independently. Reads never overtake writes because reading requires 3 full lines buffered.

Reset
REQ-025 On rst=1 (asynchronous, at any time including mid-line), the block SHALL clear wrCount, rdCount, wrSel, rdSel and pixelCount to 0, return the FSM to RD_IDLE and set o_intr=0.
REQ-026 During and after reset, o_pixel_data_valid SHALL be 0 and o_in_ready SHALL be 1. Buffer contents are don't-care, and line_buffer pointers are cleared by the next clk edge.

Verification (IMAGE_WIDTH=512)
REQ-027 Stream 1536 valid pixels (value = index mod 256) -> o_pixel_data_valid rises 2 cycles after the 1536th write. The first window is {0,1,2, 0,1,2, 0,1,2}, since each line holds 0..255,0..255.
REQ-028 Continue the stream -> o_pixel_data_valid is high for exactly 512 cycles, then o_intr pulses once, then at least 1 idle cycle. Windows at rdCount 510/511 show zero-padded columns.
REQ-029 Write 2048 pixels with no reads possible (hold the stream before the FSM starts is impossible, so force with burst) -> o_in_ready goes 0 at pixelCount=2048. Extra writes are dropped, and pixelCount stays 2048 until reads begin.
REQ-030 Write and read in the same cycle at pixelCount=1600 -> pixelCount stays 1600, and wrSel/rdSel advance independently.
REQ-031 Assert rst for 1 cycle mid-line (rdCount=200, wrSel=3) -> all counters and selects are 0, valid=0, o_intr=0. The next 1536 writes reproduce the REQ-027 response.
REQ-032 Stream 4 full images back to back (2048 lines) -> rdSel cycles 0,1,2,3,0,... and each output line matches a golden 3x3 window model.
